// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int ADD_SLICE  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a counter that must reach width-1.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/adder_slice_chain.sv
// Four-bit Kogge-Stone slice and a WIDTH-bit ripple chain of those slices.
module ks_adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_carry_in,
  output logic [3:0] o_sum,
  output logic       o_carry_out
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_gc;
  logic [3:0] w_g1;
  logic       w_p1_2;
  logic       w_p1_3;
  logic [3:0] w_g2;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carry-in folded into bit 0 generate so the prefix tree covers it.
  assign w_gc = {w_g[3:1], w_g[0] | (w_p[0] & i_carry_in)};

  assign w_g1[0] = w_gc[0];
  assign w_g1[1] = w_gc[1] | (w_p[1] & w_gc[0]);
  assign w_g1[2] = w_gc[2] | (w_p[2] & w_gc[1]);
  assign w_g1[3] = w_gc[3] | (w_p[3] & w_gc[2]);
  assign w_p1_2  = w_p[2] & w_p[1];
  assign w_p1_3  = w_p[3] & w_p[2];

  assign w_g2[0] = w_g1[0];
  assign w_g2[1] = w_g1[1];
  assign w_g2[2] = w_g1[2] | (w_p1_2 & w_g1[0]);
  assign w_g2[3] = w_g1[3] | (w_p1_3 & w_g1[1]);

  assign o_sum       = w_p ^ {w_g2[2:0], i_carry_in};
  assign o_carry_out = w_g2[3];
endmodule

module adder_slice_chain
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out
);
  localparam int N_SLICE = WIDTH / ADD_SLICE;

  logic [N_SLICE:0] w_carry;

  assign w_carry[0] = i_carry_in;

  for (genvar gi = 0; gi < N_SLICE; gi++) begin : g_slice
    ks_adder4 u_slice (
      .i_a         (i_a[gi*ADD_SLICE +: ADD_SLICE]),
      .i_b         (i_b[gi*ADD_SLICE +: ADD_SLICE]),
      .i_carry_in  (w_carry[gi]),
      .o_sum       (o_sum[gi*ADD_SLICE +: ADD_SLICE]),
      .o_carry_out (w_carry[gi+1])
    );
  end

  assign o_carry_out = w_carry[N_SLICE];
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative WIDTH x WIDTH shift-add multiplier with per-operand signedness.
// Handshake: start is consumed on any rising edge where ready=1; done pulses for one cycle when result is updated.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic               sign_en_in0,
  input  logic               sign_en_in1,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output state_t             dbg_state
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;
  logic               r_busy;
  logic               r_ready;

  logic               w_neg0;
  logic               w_neg1;
  logic [WIDTH-1:0]   w_mag0;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  assign w_neg0 = sign_en_in0 & in0[WIDTH-1];
  assign w_neg1 = sign_en_in1 & in1[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign w_mag0 = w_neg0 ? (~in0 + WIDTH'(1)) : in0;
  assign w_mag1 = w_neg1 ? (~in1 + WIDTH'(1)) : in1;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  adder_slice_chain #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a         (r_acc[2*WIDTH-1:WIDTH]),
    .i_b         (w_addend),
    .i_carry_in  (1'b0),
    .o_sum       (w_sum),
    .o_carry_out (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= w_mag0;
            r_mplier <= w_mag1;
            r_neg    <= w_neg0 ^ w_neg1;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= CALC;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        CALC: begin
          r_acc    <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= r_neg ? -r_acc : r_acc;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomized scoreboard bench for seq_shift_add_multiplier against a plain-arithmetic product model.
module tb_seq_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W       = 32;
  localparam int LATENCY = 33;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   in0;
  logic [W-1:0]   in1;
  logic           s0;
  logic           s1;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  state_t         dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  logic [2*W-1:0] last_res;

  seq_shift_add_multiplier dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in0         (in0),
    .in1         (in1),
    .sign_en_in0 (s0),
    .sign_en_in1 (s1),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sa, input logic sb);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: ready stayed low for %0d cycles, expected high", n);
      return;
    end
    in0   = a;
    in1   = b;
    s0    = sa;
    s1    = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_mul(a, b, sa, sb));
    lat_q.push_back(cyc + LATENCY);
    start = 1'b0;
    in0   = $urandom;
    in1   = $urandom;
    s0    = 1'($urandom_range(0, 1));
    s1    = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 with no outstanding request, expected 0");
        end else begin
          logic [2*W-1:0] e;
          int             c;
          e = exp_q.pop_front();
          c = lat_q.pop_front();
          chk("result", result, e);
          chk("latency_cycle", 64'(cyc), 64'(c));
          last_res = e;
        end
      end
      if (busy) chk("result_hold", result, last_res);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in0      = '0;
    in1      = '0;
    s0       = 1'b0;
    s1       = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(ready), 64'(1));
    chk("reset_result", result, 64'h0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));

    // Directed vectors; consecutive calls exercise back-to-back acceptance in DONE.
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    issue(32'h0, 32'h0, 1'b1, 1'b0);
    drain();

    // Start pulse during CALC with different operands must be ignored.
    issue(32'd1234, 32'd5678, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    in0   = 32'hDEAD_BEEF;
    in1   = 32'h1357_9BDF;
    s0    = 1'b1;
    s1    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of CALC.
    issue(32'h0BAD_F00D, 32'h7654_3210, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    lat_q.delete();
    last_res = '0;
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(ready), 64'(1));
    chk("midrst_result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd2, 32'd2, 1'b0, 1'b0);
    drain();

    // Randomized operations with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: simulation reached %0d cycles, expected completion earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
